// File: rtl/dmem_pkg.sv
// Shared types for the 64-bit word to byte-RAM arbiter.
package dmem_pkg;
  localparam int BEATS = 8;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  typedef logic port_idx_t;  // 0 = p0 (MEM stage), 1 = p1 (loader/debug)
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port not served last wins a tie.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last;  // 1 = p1 was served most recently

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     last <= 1'b1;
    else if (advance) last <= grant[1];
  end

  always_comb begin
    grant = req;
    if (&req) grant = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises 64-bit big-endian loads/stores from two ports onto a byte RAM,
// one byte per cycle, with round-robin arbitration between the ports.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int BEATS  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [63:0]       p0_addr,
  input  logic [63:0]       p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [63:0]       p1_addr,
  input  logic [63:0]       p1_wdata,
  output logic              p1_ack,
  output logic              err,
  output logic [63:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  import dmem_pkg::*;

  localparam int BW = $clog2(BEATS);

  state_t            state, state_nx;
  logic [BW-1:0]     beat;
  port_idx_t         gnt;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q, rdata_q;

  logic [1:0]  grant;
  logic        advance, sel, sel_we, oor, last_beat;
  logic [63:0] sel_addr, sel_wdata;

  assign advance = (state == IDLE) && (p0_req || p1_req);

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({p1_req, p0_req}),
    .advance (advance),
    .grant   (grant)
  );

  assign sel       = grant[1];
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;
  assign oor       = |sel_addr[63:ADDR_W];
  assign last_beat = (beat == BW'(BEATS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Outputs decode from state so a reset kills mem_we without waiting for a clock.
  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:  if (advance) state_nx = oor ? DONE : XFER;
      XFER: begin
        mem_we   = we_q;
        mem_addr = addr_q + ADDR_W'(beat);
        if (we_q) mem_wdata = data_q[63:56];
        if (last_beat) state_nx = we_q ? DONE : DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        p0_ack   = !gnt;
        p1_ack   = gnt;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // data_q shifts out store bytes MSB-first, or shifts in load bytes as they
  // return one cycle behind their address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat    <= '0;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (advance) begin
          gnt    <= sel;
          we_q   <= sel_we;
          addr_q <= sel_addr[ADDR_W-1:0];
          data_q <= sel_wdata;
          beat   <= '0;
          err_q  <= oor;
          if (oor) rdata_q <= '0;
        end
        XFER: begin
          beat <= beat + BW'(1);
          if (we_q)           data_q <= {data_q[55:0], 8'h00};
          else if (beat != 0) data_q <= {data_q[55:0], mem_rdata};
        end
        DRAIN:   rdata_q <= {data_q[55:0], mem_rdata};
        default: ;
      endcase
    end
  end

  assign rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read byte-RAM model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 8;

  logic        clock, reset_n;
  logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack, err, mem_we;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata, rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [256];
  logic        load_pat;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .BEATS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .err(err), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (load_pat) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] rd64(input logic [7:0] base);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[55:0], mem[8'(base + 8'(k))]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one request and waits (bounded) for its ack.
  task automatic xfer(input int port, input logic we, input logic [63:0] addr,
                      input logic [63:0] wd, output int lat, output logic e,
                      output logic [63:0] rd);
    if (port == 0) begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    else           begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    lat = -1; e = 1'bx; rd = 'x;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (((port == 0) ? p0_ack : p1_ack) === 1'b1) begin
        lat = i; e = err; rd = rdata;
        break;
      end
    end
    p0_req = 0; p1_req = 0;
    @(negedge clock);
    check("ack_one_cycle", {62'b0, p1_ack, p0_ack}, 64'b0);
  endtask

  initial begin
    int          lat, got, w0;
    logic        e;
    logic [63:0] rd;

    reset_n = 0; load_pat = 1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(negedge clock);
    load_pat = 0;
    check("rst_ack_err_we", {60'b0, p0_ack, p1_ack, err, mem_we}, 64'b0);
    check("rst_mem_addr",   64'(mem_addr), 64'h0);
    check("rst_mem_wdata",  64'(mem_wdata), 64'h0);
    check("rst_rdata",      rdata, 64'h0);
    reset_n = 1;
    @(negedge clock);

    // p0 store, big-endian bytes at 0x10
    xfer(0, 1, 64'h10, 64'h0123_4567_89AB_CDEF, lat, e, rd);
    check("st_latency", 64'(lat), 64'd9);
    check("st_err",     {63'b0, e}, 64'b0);
    check("st_bytes",   rd64(8'h10), 64'h0123_4567_89AB_CDEF);

    // p1 load back
    xfer(1, 0, 64'h10, 64'h0, lat, e, rd);
    check("ld_latency", 64'(lat), 64'd10);
    check("ld_err",     {63'b0, e}, 64'b0);
    check("ld_rdata",   rd, 64'h0123_4567_89AB_CDEF);

    // out-of-range load
    w0 = we_cnt;
    xfer(0, 0, 64'h100, 64'h0, lat, e, rd);
    check("oor_latency", 64'(lat), 64'd1);
    check("oor_err",     {63'b0, e}, 64'd1);
    check("oor_rdata",   rd, 64'h0);
    check("oor_no_write", 64'(we_cnt - w0), 64'd0);

    // store wrapping past the top of the RAM
    xfer(1, 1, 64'hFC, 64'h1122_3344_5566_7788, lat, e, rd);
    check("wrap_latency", 64'(lat), 64'd9);
    check("wrap_err",     {63'b0, e}, 64'b0);
    check("wrap_bytes",   rd64(8'hFC), 64'h1122_3344_5566_7788);
    check("wrap_rdata_hold", rd, 64'h0);

    // both ports requesting from reset: grants alternate
    reset_n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 64'h20;
    p1_req = 1; p1_we = 0; p1_addr = 64'h30;
    @(negedge clock);
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      got = -1; rd = 'x;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        if (p0_ack === 1'b1) begin got = 0; rd = rdata; break; end
        if (p1_ack === 1'b1) begin got = 1; rd = rdata; break; end
      end
      check($sformatf("rr_grant_%0d", k), 64'(got), 64'(k % 2));
      check($sformatf("rr_rdata_%0d", k), rd,
            (k % 2 == 0) ? 64'h8584_8786_8180_8382 : 64'h9594_9796_9190_9392);
    end
    p0_req = 0; p1_req = 0;
    @(negedge clock);

    // reset during beat 3 of a store
    p0_req = 1; p0_we = 1; p0_addr = 64'h40; p0_wdata = 64'hAABB_CCDD_EEFF_0011;
    repeat (4) @(negedge clock);
    check("abort_we_before", {63'b0, mem_we}, 64'd1);
    check("abort_addr_beat3", 64'(mem_addr), 64'h43);
    check("abort_wdata_beat3", 64'(mem_wdata), 64'hDD);
    reset_n = 0; p0_req = 0;
    #1;
    check("abort_we_drop", {63'b0, mem_we}, 64'b0);
    @(negedge clock);
    check("abort_no_ack", {62'b0, p1_ack, p0_ack}, 64'b0);
    check("abort_rdata_clr", rdata, 64'h0);
    reset_n = 1;
    @(negedge clock);
    check("abort_no_ack_after", {62'b0, p1_ack, p0_ack}, 64'b0);
    check("abort_bytes", rd64(8'h40), 64'hAABB_CCE6_E1E0_E3E2);
    xfer(1, 0, 64'h40, 64'h0, lat, e, rd);
    check("abort_idle_latency", 64'(lat), 64'd10);
    check("abort_readback", rd, 64'hAABB_CCE6_E1E0_E3E2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
